// File: rtl/round_key_bank_if.sv
// Handshake and data bundle between key expansion / round engine (master) and the round-key bank (slave).
interface round_key_bank_if #(
    parameter int WIDTH = 128,
    parameter int IDX_W = 4
);
    logic             clr;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [WIDTH-1:0] wr_key;
    logic             rd_en;
    logic [IDX_W-1:0] rd_idx;
    logic             seq_start;
    logic             seq_dir;
    logic             key_ready;
    logic             key_valid;
    logic [WIDTH-1:0] key_out;
    logic [IDX_W-1:0] key_idx;
    logic             key_last;
    logic             busy;
    logic             all_loaded;
    logic             err;

    modport master (
        output clr, wr_en, wr_idx, wr_key, rd_en, rd_idx, seq_start, seq_dir, key_ready,
        input  key_valid, key_out, key_idx, key_last, busy, all_loaded, err
    );

    modport slave (
        input  clr, wr_en, wr_idx, wr_key, rd_en, rd_idx, seq_start, seq_dir, key_ready,
        output key_valid, key_out, key_idx, key_last, busy, all_loaded, err
    );
endinterface

// File: rtl/round_key_bank.sv
// Round-key store with random read and ascending/descending bursts; key appears one cycle after accept.
// Output register holds while key_valid && !key_ready; reads and burst starts are refused until it frees.
module round_key_bank #(
    parameter int WIDTH    = 128,
    parameter int NUM_KEYS = 11,
    parameter int IDX_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    round_key_bank_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_KEYS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state_q, state_d;
    logic                  dir_q, dir_d;
    logic [NUM_KEYS-1:0]   loaded_q, loaded_d;
    logic                  all_loaded_q, all_loaded_d;
    logic                  key_valid_q, key_valid_d;
    logic [WIDTH-1:0]      key_out_q, key_out_d;
    logic [IDX_W-1:0]      key_idx_q, key_idx_d;
    logic                  key_last_q, key_last_d;
    logic                  err_q, err_d;
    logic [WIDTH-1:0]      mem_q [NUM_KEYS];

    logic                  busy, slot_free, wr_ok, wr_bad, rd_acc;
    logic                  start_ok, start_err, beat_acc;
    logic [IDX_W-1:0]      first_idx, step_idx, sel_idx;
    logic [WIDTH-1:0]      sel_key;
    logic                  sel_loaded;

    assign busy      = (state_q == RUN);
    assign slot_free = !key_valid_q || bus.key_ready;
    assign wr_ok     = bus.wr_en && !bus.clr && !busy && (bus.wr_idx <= LAST_IDX);
    assign wr_bad    = bus.wr_en && !bus.clr && (busy || (bus.wr_idx > LAST_IDX));
    assign rd_acc    = bus.rd_en && !busy && slot_free && !bus.seq_start;
    assign start_ok  = !busy && bus.seq_start && all_loaded_q && slot_free;
    assign start_err = !busy && bus.seq_start && !all_loaded_q;
    assign beat_acc  = busy && key_valid_q && bus.key_ready;
    assign first_idx = bus.seq_dir ? LAST_IDX : '0;
    assign step_idx  = dir_q ? (key_idx_q - IDX_W'(1)) : (key_idx_q + IDX_W'(1));
    // One shared read port: next burst index, burst start index, or random read index.
    assign sel_idx   = busy ? step_idx : (bus.seq_start ? first_idx : bus.rd_idx);

    always_comb begin
        sel_key    = '0;
        sel_loaded = 1'b0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_key    = mem_q[i];
                sel_loaded = loaded_q[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        loaded_d     = loaded_q;
        key_valid_d  = key_valid_q;
        key_out_d    = key_out_q;
        key_idx_d    = key_idx_q;
        key_last_d   = key_last_q;
        err_d        = wr_bad || start_err;
        all_loaded_d = !bus.clr && (&loaded_q);

        if (bus.clr) begin
            loaded_d = '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (bus.wr_idx == IDX_W'(i)) loaded_d[i] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (slot_free) key_valid_d = 1'b0;
                if (start_ok) begin
                    state_d     = RUN;
                    dir_d       = bus.seq_dir;
                    key_valid_d = 1'b1;
                    key_idx_d   = first_idx;
                    key_out_d   = sel_key;
                    key_last_d  = (NUM_KEYS == 1);
                end else if (rd_acc) begin
                    key_valid_d = 1'b1;
                    key_idx_d   = bus.rd_idx;
                    key_last_d  = 1'b0;
                    key_out_d   = sel_loaded ? sel_key : '0;
                    if (!sel_loaded) err_d = 1'b1;
                end
            end
            RUN: begin
                if (beat_acc) begin
                    if (key_last_q) begin
                        state_d     = IDLE;
                        key_valid_d = 1'b0;
                        key_last_d  = 1'b0;
                    end else begin
                        key_idx_d  = step_idx;
                        key_out_d  = sel_key;
                        key_last_d = dir_q ? (step_idx == '0) : (step_idx == LAST_IDX);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dir_q        <= 1'b0;
            loaded_q     <= '0;
            all_loaded_q <= 1'b0;
            key_valid_q  <= 1'b0;
            key_out_q    <= '0;
            key_idx_q    <= '0;
            key_last_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            loaded_q     <= loaded_d;
            all_loaded_q <= all_loaded_d;
            key_valid_q  <= key_valid_d;
            key_out_q    <= key_out_d;
            key_idx_q    <= key_idx_d;
            key_last_q   <= key_last_d;
            err_q        <= err_d;
        end
    end

    // Key storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (bus.wr_idx == IDX_W'(i)) mem_q[i] <= bus.wr_key;
            end
        end
    end

    assign bus.key_valid  = key_valid_q;
    assign bus.key_out    = key_out_q;
    assign bus.key_idx    = key_idx_q;
    assign bus.key_last   = key_last_q;
    assign bus.busy       = busy;
    assign bus.all_loaded = all_loaded_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_round_key_bank.sv
// Directed bench for round_key_bank: load, random read, both burst directions, stalls, errors, reset.
module tb_round_key_bank;
    localparam int WIDTH = 128;
    localparam int NUM_KEYS = 11;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    round_key_bank_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    round_key_bank #(.WIDTH(WIDTH), .NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [WIDTH-1:0] key_of(int i);
        logic [7:0] b;
        b = 8'(i);
        return {16{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        int drain;
        bus.clr = 0; bus.wr_en = 0; bus.wr_idx = '0; bus.wr_key = '0;
        bus.rd_en = 0; bus.rd_idx = '0; bus.seq_start = 0; bus.seq_dir = 0; bus.key_ready = 0;
        tick(); tick();
        rst = 0;
        chk("rst_valid", bus.key_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_all_loaded", bus.all_loaded, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_key_out", bus.key_out, 0);
        chk("rst_key_idx", bus.key_idx, 0);
        chk("rst_key_last", bus.key_last, 0);

        // 1: load all keys
        for (int i = 0; i < NUM_KEYS; i++) begin
            bus.wr_en = 1; bus.wr_idx = 4'(i); bus.wr_key = key_of(i);
            tick();
            chk("load_err", bus.err, 0);
        end
        bus.wr_en = 0;
        chk("all_loaded_early", bus.all_loaded, 0);
        tick();
        chk("all_loaded", bus.all_loaded, 1);

        // 2: random reads
        bus.key_ready = 1;
        bus.rd_en = 1; bus.rd_idx = 4'd5;
        tick();
        bus.rd_en = 0;
        chk("rd5_valid", bus.key_valid, 1);
        chk("rd5_idx", bus.key_idx, 5);
        chk("rd5_key", bus.key_out, key_of(5));
        chk("rd5_last", bus.key_last, 0);
        chk("rd5_err", bus.err, 0);
        bus.rd_en = 1; bus.rd_idx = 4'd12;
        tick();
        bus.rd_en = 0;
        chk("rd12_valid", bus.key_valid, 1);
        chk("rd12_idx", bus.key_idx, 12);
        chk("rd12_key", bus.key_out, 0);
        chk("rd12_err", bus.err, 1);
        tick();
        chk("rd12_err_pulse", bus.err, 0);
        chk("rd_drained", bus.key_valid, 0);

        // 3: ascending burst
        bus.seq_start = 1; bus.seq_dir = 0;
        tick();
        bus.seq_start = 0;
        for (int b = 0; b < NUM_KEYS; b++) begin
            chk("asc_valid", bus.key_valid, 1);
            chk("asc_idx", bus.key_idx, WIDTH'(b));
            chk("asc_key", bus.key_out, key_of(b));
            chk("asc_last", bus.key_last, WIDTH'(b == NUM_KEYS - 1));
            chk("asc_busy", bus.busy, 1);
            tick();
        end
        chk("asc_busy_end", bus.busy, 0);
        chk("asc_valid_end", bus.key_valid, 0);

        // 4: descending burst with a stall at index 7
        bus.seq_start = 1; bus.seq_dir = 1;
        tick();
        bus.seq_start = 0; bus.seq_dir = 0;
        for (int e = NUM_KEYS - 1; e >= 0; e--) begin
            chk("dsc_idx", bus.key_idx, WIDTH'(e));
            chk("dsc_key", bus.key_out, key_of(e));
            chk("dsc_last", bus.key_last, WIDTH'(e == 0));
            if (e == 7) begin
                bus.key_ready = 0;
                repeat (3) begin
                    tick();
                    chk("stall_valid", bus.key_valid, 1);
                    chk("stall_idx", bus.key_idx, 7);
                    chk("stall_key", bus.key_out, key_of(7));
                end
                bus.key_ready = 1;
            end
            tick();
        end
        chk("dsc_busy_end", bus.busy, 0);
        chk("dsc_valid_end", bus.key_valid, 0);

        // 5: start refused with a missing key; write while busy is ignored
        bus.clr = 1;
        tick();
        bus.clr = 0;
        chk("clr_all_loaded", bus.all_loaded, 0);
        for (int i = 0; i < NUM_KEYS - 1; i++) begin
            bus.wr_en = 1; bus.wr_idx = 4'(i); bus.wr_key = key_of(i);
            tick();
        end
        bus.wr_en = 0;
        tick();
        bus.seq_start = 1;
        tick();
        bus.seq_start = 0;
        chk("partial_err", bus.err, 1);
        chk("partial_busy", bus.busy, 0);
        chk("partial_valid", bus.key_valid, 0);
        bus.wr_en = 1; bus.wr_idx = 4'(NUM_KEYS - 1); bus.wr_key = key_of(NUM_KEYS - 1);
        tick();
        bus.wr_en = 0;
        tick();
        chk("reload_all_loaded", bus.all_loaded, 1);
        bus.seq_start = 1;
        tick();
        bus.seq_start = 0;
        chk("burst2_busy", bus.busy, 1);
        bus.wr_en = 1; bus.wr_idx = 4'd3; bus.wr_key = '1;
        tick();
        bus.wr_en = 0;
        chk("busy_wr_err", bus.err, 1);
        drain = 0;
        while (bus.busy && drain < 20) begin
            tick();
            drain++;
        end
        chk("burst2_drain", bus.busy, 0);
        bus.rd_en = 1; bus.rd_idx = 4'd3;
        tick();
        bus.rd_en = 0;
        chk("busy_wr_ignored", bus.key_out, key_of(3));
        tick();

        // 6: reset mid-burst
        bus.seq_start = 1; bus.seq_dir = 0;
        tick();
        bus.seq_start = 0;
        repeat (4) tick();
        chk("beat4_idx", bus.key_idx, 4);
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_valid", bus.key_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_all_loaded", bus.all_loaded, 0);
        chk("mid_rst_idx", bus.key_idx, 0);
        bus.seq_start = 1;
        tick();
        bus.seq_start = 0;
        chk("post_rst_err", bus.err, 1);
        chk("post_rst_busy", bus.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
